// File: rtl/bp_cce_pkg.sv
// Shared definitions for the CCE microcode fetch slice: predecode field
// positions within a microcode instruction and the fetch FSM state type.
package bp_cce_pkg;

  // Predecode field layout (LSB-aligned so it fits any instruction width
  // of at least cce_pc_width_p + 2 bits).
  localparam int branch_bit_lp  = 0;
  localparam int predict_bit_lp = 1;
  localparam int target_lsb_lp  = 2;

  typedef enum logic {
    e_boot  = 1'b0,
    e_fetch = 1'b1
  } bp_cce_fetch_state_e;

endpackage

// File: rtl/bp_cce_inst_ram.sv
// Microcode instruction store: one write port, one synchronous read port.
// The read register only updates when r_v_i is high, so the output holds
// its last value while the fetch stage is stalled.
module bp_cce_inst_ram #(
  parameter int width_p      = 16,
  parameter int addr_width_p = 4
) (
  input  logic                    clk_i,
  input  logic                    w_v_i,
  input  logic [addr_width_p-1:0] w_addr_i,
  input  logic [width_p-1:0]      w_data_i,
  input  logic                    r_v_i,
  input  logic [addr_width_p-1:0] r_addr_i,
  output logic [width_p-1:0]      r_data_o
);

  localparam int depth_lp = 1 << addr_width_p;

  logic [width_p-1:0] mem_reg [depth_lp];

  // Write and registered read; no reset so this maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      mem_reg[w_addr_i] <= w_data_i;
    end
    if (r_v_i) begin
      r_data_o <= mem_reg[r_addr_i];
    end
  end

endmodule

// File: rtl/bp_cce_fetch.sv
// CCE microcode fetch stage. Boots by accepting microcode writes, then on
// start_i fetches from PC 0 with static branch prediction from the
// predecoded RAM output. A mispredict squashes the current instruction and
// refetches from the redirect PC after a one-cycle bubble.
module bp_cce_fetch
  import bp_cce_pkg::*;
#(
  parameter int cce_pc_width_p = 4,
  parameter int inst_width_p   = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      cfg_w_v_i,
  input  logic [cce_pc_width_p-1:0] cfg_addr_i,
  input  logic [inst_width_p-1:0]   cfg_data_i,
  input  logic                      start_i,
  output logic [inst_width_p-1:0]   inst_o,
  output logic [cce_pc_width_p-1:0] pc_o,
  output logic                      inst_v_o,
  input  logic                      inst_yumi_i,
  output logic                      branch_o,
  output logic                      predicted_taken_o,
  output logic [cce_pc_width_p-1:0] branch_target_o,
  input  logic                      mispredict_i,
  input  logic [cce_pc_width_p-1:0] redirect_pc_i
);

  bp_cce_fetch_state_e       state_reg;
  logic [cce_pc_width_p-1:0] fetch_pc_reg;
  logic [cce_pc_width_p-1:0] pc_reg;
  logic                      inst_v_reg;

  logic [inst_width_p-1:0]   ram_data;
  logic                      ram_w_v;
  logic                      ram_r_v;
  logic [cce_pc_width_p-1:0] ram_r_addr;
  logic [cce_pc_width_p-1:0] next_pc;

  bp_cce_inst_ram #(
    .width_p      (inst_width_p),
    .addr_width_p (cce_pc_width_p)
  ) inst_ram (
    .clk_i    (clk_i),
    .w_v_i    (ram_w_v),
    .w_addr_i (cfg_addr_i),
    .w_data_i (cfg_data_i),
    .r_v_i    (ram_r_v),
    .r_addr_i (ram_r_addr),
    .r_data_o (ram_data)
  );

  assign inst_o   = ram_data;
  assign pc_o     = pc_reg;
  assign inst_v_o = inst_v_reg;

  // Predecode is gated by valid so reset and squash bubbles read as zero
  // even though the RAM output register itself is never reset.
  assign branch_o          = inst_v_reg & ram_data[branch_bit_lp];
  assign predicted_taken_o = branch_o & ram_data[predict_bit_lp];
  assign branch_target_o   = inst_v_reg ? ram_data[target_lsb_lp +: cce_pc_width_p] : '0;

  // Sequential successor, natural wrap from all-ones back to zero.
  assign next_pc = predicted_taken_o ? branch_target_o : pc_reg + cce_pc_width_p'(1);

  // Microcode is only writable while booting.
  assign ram_w_v = (state_reg == e_boot) && cfg_w_v_i;

  // Choose when and where to read the RAM; no read during a stall keeps inst_o intact.
  always_comb begin
    ram_r_v    = 1'b0;
    ram_r_addr = fetch_pc_reg;
    if (state_reg == e_boot) begin
      if (start_i) begin
        ram_r_v    = 1'b1;
        ram_r_addr = '0;
      end
    end else if (!mispredict_i) begin
      if (!inst_v_reg) begin
        ram_r_v    = 1'b1;
        ram_r_addr = fetch_pc_reg;
      end else if (inst_yumi_i) begin
        ram_r_v    = 1'b1;
        ram_r_addr = next_pc;
      end
    end
  end

  // Fetch FSM with registered valid, PC and fetch PC.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg    <= e_boot;
      fetch_pc_reg <= '0;
      pc_reg       <= '0;
      inst_v_reg   <= 1'b0;
    end else begin
      case (state_reg)
        e_boot: begin
          if (start_i) begin
            state_reg    <= e_fetch;
            fetch_pc_reg <= '0;
            pc_reg       <= '0;
            inst_v_reg   <= 1'b1;
          end
        end
        e_fetch: begin
          if (mispredict_i) begin
            // Squash; the redirect is read on the following bubble cycle.
            fetch_pc_reg <= redirect_pc_i;
            inst_v_reg   <= 1'b0;
          end else if (!inst_v_reg) begin
            pc_reg     <= fetch_pc_reg;
            inst_v_reg <= 1'b1;
          end else if (inst_yumi_i) begin
            fetch_pc_reg <= next_pc;
            pc_reg       <= next_pc;
          end
        end
        default: begin
          state_reg <= e_boot;
        end
      endcase
    end
  end

endmodule
